// File: rtl/mult_trojan_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_trojan_scan_ctrl
//  Description : Self-test sequencer for a combinational WIDTHxWIDTH array
//                multiplier. Each vector is applied to the multiplier, allowed
//                to settle for SETTLE_CYCLES, and its product is compared with
//                a golden a*b. Mismatches are counted (saturating) and the
//                first failing vector is captured. The first four vectors are
//                directed patterns; the rest come from a 32-bit Galois LFSR.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                start_i, seed_i - run request and LFSR seed (0 = default)
//                mult_a_o/_b_o   - registered operands to the multiplier
//                mult_p_i        - product returned by the multiplier
//                busy_o, done_o, pass_o - run status
//                err_cnt_o, vec_cnt_o   - mismatch / vector counters
//                fail_a_o/_b_o/_p_o     - first mismatching vector
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_trojan_scan_ctrl #(
    parameter int          WIDTH         = 16,
    parameter int          NUM_VECTORS   = 1024,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED     = 32'hACE11234,
    parameter int          ERR_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [31:0]          seed_i,
    output logic [WIDTH-1:0]     mult_a_o,
    output logic [WIDTH-1:0]     mult_b_o,
    input  logic [2*WIDTH-1:0]   mult_p_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic [15:0]          vec_cnt_o,
    output logic [WIDTH-1:0]     fail_a_o,
    output logic [WIDTH-1:0]     fail_b_o,
    output logic [2*WIDTH-1:0]   fail_p_o
);

    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] c_LFSR_MASK = 32'h8020_0003;
    localparam int          c_SW        = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_SW-1:0] c_SETTLE = c_SW'(SETTLE_CYCLES);
    localparam logic [15:0] c_NUM_VEC   = 16'(NUM_VECTORS);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q;
    logic [31:0]          lfsr_q;
    logic [c_SW-1:0]      settle_q;
    logic [2*WIDTH-1:0]   exp_q;
    logic [WIDTH-1:0]     mult_a_q;
    logic [WIDTH-1:0]     mult_b_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ERR_W-1:0]     err_cnt_q;
    logic [15:0]          vec_cnt_q;
    logic [WIDTH-1:0]     fail_a_q;
    logic [WIDTH-1:0]     fail_b_q;
    logic [2*WIDTH-1:0]   fail_p_q;

    logic [WIDTH-1:0]     w_alt;
    logic [WIDTH-1:0]     w_lfsr_a;
    logic [WIDTH-1:0]     w_lfsr_b;
    logic [WIDTH-1:0]     w_vec_a;
    logic [WIDTH-1:0]     w_vec_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic [31:0]          w_lfsr_next;
    logic [15:0]          w_vec_next;
    logic                 w_mismatch;

    // Alternating 1010... pattern sized to WIDTH (0xAAAA at 16 bits)
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_alt
            assign w_alt[gi] = (gi % 2) == 1;
        end
    endgenerate

    // LFSR halves fitted to WIDTH: zero-extended if wider, truncated if narrower
    generate
        if (WIDTH == 16) begin : g_lfsr_eq
            assign w_lfsr_a = lfsr_q[31:16];
            assign w_lfsr_b = lfsr_q[15:0];
        end else if (WIDTH > 16) begin : g_lfsr_wide
            assign w_lfsr_a = {{(WIDTH-16){1'b0}}, lfsr_q[31:16]};
            assign w_lfsr_b = {{(WIDTH-16){1'b0}}, lfsr_q[15:0]};
        end else begin : g_lfsr_narrow
            assign w_lfsr_a = lfsr_q[16+WIDTH-1:16];
            assign w_lfsr_b = lfsr_q[WIDTH-1:0];
        end
    endgenerate

    // Vector source selected by the index of the vector about to be applied
    always_comb begin
        w_vec_a = w_lfsr_a;
        w_vec_b = w_lfsr_b;
        case (vec_cnt_q)
            16'd0: begin w_vec_a = '0;    w_vec_b = '0;    end
            16'd1: begin w_vec_a = '1;    w_vec_b = '1;    end
            16'd2: begin w_vec_a = w_alt; w_vec_b = w_alt; end
            16'd3: begin w_vec_a = '1;    w_vec_b = c_ONE; end
            default: ;
        endcase
    end

    assign w_prod      = {{WIDTH{1'b0}}, w_vec_a} * {{WIDTH{1'b0}}, w_vec_b};
    assign w_lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_LFSR_MASK) : (lfsr_q >> 1);
    assign w_vec_next  = vec_cnt_q + 16'd1;
    assign w_mismatch  = (mult_p_i != exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= '0;
            settle_q  <= '0;
            exp_q     <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
            vec_cnt_q <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_p_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        err_cnt_q <= '0;
                        vec_cnt_q <= '0;
                        fail_a_q  <= '0;
                        fail_b_q  <= '0;
                        fail_p_q  <= '0;
                        lfsr_q    <= (seed_i == 32'd0) ? LFSR_SEED : seed_i;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    mult_a_q <= w_vec_a;
                    mult_b_q <= w_vec_b;
                    exp_q    <= w_prod;
                    settle_q <= c_SETTLE;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle_q <= settle_q - 1'b1;
                    if (settle_q == c_SW'(1)) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        // Only the first failure of a run is captured
                        if (err_cnt_q == '0) begin
                            fail_a_q <= mult_a_q;
                            fail_b_q <= mult_b_q;
                            fail_p_q <= mult_p_i;
                        end
                    end
                    vec_cnt_q <= w_vec_next;
                    if (vec_cnt_q >= 16'd4) begin
                        lfsr_q <= w_lfsr_next;
                    end
                    if (w_vec_next == c_NUM_VEC) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_APPLY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mult_a_o  = mult_a_q;
    assign mult_b_o  = mult_b_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = done_q && (err_cnt_q == '0);
    assign err_cnt_o = err_cnt_q;
    assign vec_cnt_o = vec_cnt_q;
    assign fail_a_o  = fail_a_q;
    assign fail_b_o  = fail_b_q;
    assign fail_p_o  = fail_p_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_trojan_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_trojan_scan_ctrl
//  Description : Directed self-checking bench for mult_trojan_scan_ctrl with a
//                behavioural multiplier that can be clean, Trojan-infected
//                (wrong product when A==B, A!=0) or stuck at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_trojan_scan_ctrl;

    localparam int c_W   = 16;
    localparam int c_NV  = 64;
    localparam int c_ST  = 2;
    localparam int c_EW  = 4;
    localparam int c_VL  = c_ST + 2;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [31:0]       seed_i;
    logic [c_W-1:0]    mult_a_o;
    logic [c_W-1:0]    mult_b_o;
    logic [2*c_W-1:0]  mult_p_i;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [c_EW-1:0]   err_cnt_o;
    logic [15:0]       vec_cnt_o;
    logic [c_W-1:0]    fail_a_o;
    logic [c_W-1:0]    fail_b_o;
    logic [2*c_W-1:0]  fail_p_o;

    int                mode;
    int                checks;
    int                errors;
    int                cyc;
    logic [c_W-1:0]    snap_a;
    logic [c_W-1:0]    snap_b;
    logic [31:0]       l;

    mult_trojan_scan_ctrl #(
        .WIDTH        (c_W),
        .NUM_VECTORS  (c_NV),
        .SETTLE_CYCLES(c_ST),
        .LFSR_SEED    (32'hACE11234),
        .ERR_W        (c_EW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .seed_i    (seed_i),
        .mult_a_o  (mult_a_o),
        .mult_b_o  (mult_b_o),
        .mult_p_i  (mult_p_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .pass_o    (pass_o),
        .err_cnt_o (err_cnt_o),
        .vec_cnt_o (vec_cnt_o),
        .fail_a_o  (fail_a_o),
        .fail_b_o  (fail_b_o),
        .fail_p_o  (fail_p_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier under test: 0 clean, 1 Trojan (LSB flipped when A==B!=0), 2 stuck-at-0
    always_comb begin
        mult_p_i = {16'd0, mult_a_o} * {16'd0, mult_b_o};
        if (mode == 1 && mult_a_o == mult_b_o && mult_a_o != 16'd0) begin
            mult_p_i = mult_p_i ^ 32'd1;
        end else if (mode == 2) begin
            mult_p_i = 32'd0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Accept a start; returns #1 after the accepting edge
    task automatic do_start(input logic [31:0] seed);
        @(negedge clk);
        start_i = 1'b1;
        seed_i  = seed;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
    endtask

    // Counts edges from the accepting edge until done_o; snapshots operands of
    // vector snap_vec; pulses start_i for one cycle at cycle pulse_at
    task automatic wait_done(input int snap_vec, input int pulse_at, output int cycles);
        cycles = 0;
        while (!done_o && cycles < 5000) begin
            start_i = (cycles == pulse_at);
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == snap_vec * c_VL + 1) begin
                snap_a = mult_a_o;
                snap_b = mult_b_o;
            end
        end
        start_i = 1'b0;
        if (!done_o) chk("done_timeout", 0, 1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mode    = 0;
        rst     = 1'b1;
        start_i = 1'b0;
        seed_i  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_done_pass", {done_o, pass_o}, 0);
        chk("reset_ops", {mult_a_o, mult_b_o}, 0);
        chk("reset_cnts", {err_cnt_o, vec_cnt_o}, 0);
        chk("reset_fail", {fail_a_o, fail_b_o, fail_p_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: clean multiplier, default seed; also snapshot vector 4
        do_start(32'd0);
        wait_done(4, -1, cyc);
        chk("t1_cycles", cyc, 256);
        chk("t1_pass", pass_o, 1);
        chk("t1_err", err_cnt_o, 0);
        chk("t1_vec", vec_cnt_o, 64);
        chk("t1_busy", busy_o, 0);
        chk("t1_idx4_ops", {snap_a, snap_b}, 32'hACE1_1234);

        // T6: explicit seed equal to default gives identical operands
        l = 32'hACE11234;
        repeat (59) l = lfsr_step(l);
        chk("t6_last_ops_seed0", {mult_a_o, mult_b_o}, l);
        do_start(32'hACE11234);
        wait_done(4, -1, cyc);
        chk("t6_idx4_ops", {snap_a, snap_b}, 32'hACE1_1234);
        chk("t6_last_ops_seed", {mult_a_o, mult_b_o}, l);
        // A different seed must change the LFSR operands
        do_start(32'h0000_0001);
        wait_done(5, -1, cyc);
        chk("t6_idx5_other_seed", {snap_a, snap_b}, lfsr_step(32'h1));

        // T2: Trojan multiplier, first failure is FFFF x FFFF
        mode = 1;
        do_start(32'd0);
        wait_done(1, -1, cyc);
        chk("t2_idx1_ops", {snap_a, snap_b}, 32'hFFFF_FFFF);
        chk("t2_pass", pass_o, 0);
        chk("t2_fail_ab", {fail_a_o, fail_b_o}, 32'hFFFF_FFFF);
        chk("t2_fail_p", fail_p_o, 32'hFFFE_0000);

        // T3: stuck-at-zero multiplier; idx0 passes, count saturates
        mode = 2;
        do_start(32'd0);
        wait_done(3, -1, cyc);
        chk("t3_idx3_ops", {snap_a, snap_b}, 32'hFFFF_0001);
        chk("t3_err_sat", err_cnt_o, 15);
        chk("t3_fail_ab", {fail_a_o, fail_b_o}, 32'hFFFF_FFFF);
        chk("t3_fail_p", fail_p_o, 0);
        chk("t3_pass", pass_o, 0);
        chk("t3_vec", vec_cnt_o, 64);

        // T5: clean again; start pulse during CHECK of vector 0 is ignored
        mode = 0;
        do_start(32'd0);
        wait_done(2, 3, cyc);
        chk("t5_idx2_ops", {snap_a, snap_b}, 32'hAAAA_AAAA);
        chk("t5_cycles", cyc, 256);
        chk("t5_vec", vec_cnt_o, 64);
        chk("t5_err_cleared", err_cnt_o, 0);
        chk("t5_fail_cleared", {fail_a_o, fail_b_o, fail_p_o}, 0);

        // T4: reset during SETTLE of vector 10 (after edge 10*4+2)
        mode = 1;
        do_start(32'd0);
        repeat (10 * c_VL + 1) @(posedge clk);
        #1;
        chk("t4_vec_before_rst", vec_cnt_o, 10);
        chk("t4_err_before_rst", err_cnt_o, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_rst_status", {busy_o, done_o, pass_o}, 0);
        chk("t4_rst_ops", {mult_a_o, mult_b_o}, 0);
        chk("t4_rst_cnts", {err_cnt_o, vec_cnt_o}, 0);
        chk("t4_rst_fail", {fail_a_o, fail_b_o, fail_p_o}, 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        do_start(32'd0);
        wait_done(1, -1, cyc);
        chk("t4_rerun_idx1", {snap_a, snap_b}, 32'hFFFF_FFFF);
        chk("t4_rerun_cycles", cyc, 256);
        chk("t4_rerun_pass", pass_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
